// File: rtl/sprite_motion_ctrl.sv
// Per-frame game-state engine: moves ship, bullet and rock on each frame_tick, resolves collisions, keeps score.
// Build option: define AUTOFIRE_EN for level-triggered auto-repeat fire; default is one shot per press.
module sprite_motion_ctrl #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned SHIP_W      = 100,
  parameter int unsigned SHIP_H      = 100,
  parameter int unsigned BULLET_W    = 20,
  parameter int unsigned BULLET_H    = 20,
  parameter int unsigned ROCK_W      = 100,
  parameter int unsigned ROCK_H      = 100,
  parameter int unsigned SHIP_STEP   = 4,
  parameter int unsigned BULLET_STEP = 8,
  parameter int unsigned ROCK_STEP   = 2,
  parameter int unsigned SHIP_X0     = 270,
  parameter int unsigned SHIP_Y0     = 370
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  output logic [18:0] x_ship,
  output logic [18:0] y_ship,
  output logic [18:0] x_bullet,
  output logic [18:0] y_bullet,
  output logic [18:0] x_rock,
  output logic [18:0] y_rock,
  output logic        bullet_active,
  output logic [7:0]  score,
  output logic        hit,
  output logic        game_over,
  output logic [1:0]  dbg_state
);

  localparam logic [18:0] SCR_W    = 19'(SCREEN_W);
  localparam logic [18:0] SCR_H    = 19'(SCREEN_H);
  localparam logic [18:0] SHP_W    = 19'(SHIP_W);
  localparam logic [18:0] SHP_H    = 19'(SHIP_H);
  localparam logic [18:0] BUL_W    = 19'(BULLET_W);
  localparam logic [18:0] BUL_H    = 19'(BULLET_H);
  localparam logic [18:0] RCK_W    = 19'(ROCK_W);
  localparam logic [18:0] RCK_H    = 19'(ROCK_H);
  localparam logic [18:0] SHP_STEP = 19'(SHIP_STEP);
  localparam logic [18:0] BUL_STEP = 19'(BULLET_STEP);
  localparam logic [18:0] RCK_STEP = 19'(ROCK_STEP);
  localparam logic [18:0] SHP_X0   = 19'(SHIP_X0);
  localparam logic [18:0] SHP_Y0   = 19'(SHIP_Y0);
  localparam logic [18:0] SHP_SPAN = 19'(SCREEN_W - SHIP_W);
  localparam logic [18:0] RCK_SPAN = 19'(SCREEN_W - ROCK_W);
  localparam logic [18:0] BUL_OFS  = 19'((SHIP_W - BULLET_W) / 2);
  localparam logic [18:0] RCK_X0   = 19'(270);

  typedef enum logic [1:0] {ST_WAIT = 2'd0, ST_MOVE = 2'd1, ST_CHECK = 2'd2} state_t;

  state_t      state_q;
  logic [18:0] x_ship_q, y_ship_q, x_bullet_q, y_bullet_q, x_rock_q, y_rock_q;
  logic        bullet_active_q, hit_q, game_over_q, fire_req_q;
  logic [7:0]  score_q;
  logic [15:0] lfsr_q;
  logic        lfsr_fb, fire_set;

  logic [18:0] respawn_x_d, ship_x_mv_d, bul_x_mv_d, bul_y_mv_d, rock_x_mv_d, rock_y_mv_d;
  logic [18:0] rock_x_ck_d, rock_y_ck_d;
  logic        bul_act_mv_d, bul_hit_d, ship_hit_d;

  function automatic logic boxes_overlap(
    input logic [18:0] ax, input logic [18:0] ay, input logic [18:0] aw, input logic [18:0] ah,
    input logic [18:0] bx, input logic [18:0] by, input logic [18:0] bw, input logic [18:0] bh);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

`ifdef AUTOFIRE_EN
  assign fire_set = btn_fire && (state_q == ST_WAIT);
`else
  logic btn_fire_q;
  always_ff @(posedge clock) begin
    if (reset) btn_fire_q <= 1'b0;
    else       btn_fire_q <= btn_fire;
  end
  assign fire_set = btn_fire && !btn_fire_q;
`endif

  // MOVE and CHECK results, both computed from the currently registered positions.
  always_comb begin
    respawn_x_d = {9'd0, lfsr_q[9:0]};
    if (respawn_x_d >= RCK_SPAN) respawn_x_d = respawn_x_d - RCK_SPAN;

    ship_x_mv_d = x_ship_q;
    if (btn_left && !btn_right)
      ship_x_mv_d = (x_ship_q >= SHP_STEP) ? x_ship_q - SHP_STEP : 19'd0;
    else if (btn_right && !btn_left)
      ship_x_mv_d = (x_ship_q + SHP_STEP > SHP_SPAN) ? SHP_SPAN : x_ship_q + SHP_STEP;

    bul_x_mv_d   = x_bullet_q;
    bul_y_mv_d   = y_bullet_q;
    bul_act_mv_d = bullet_active_q;
    if (bullet_active_q) begin
      if (y_bullet_q < BUL_STEP) begin
        bul_x_mv_d   = SCR_W;
        bul_y_mv_d   = SCR_H;
        bul_act_mv_d = 1'b0;
      end else begin
        bul_y_mv_d = y_bullet_q - BUL_STEP;
      end
    end else if (fire_req_q) begin
      bul_x_mv_d   = x_ship_q + BUL_OFS;
      bul_y_mv_d   = y_ship_q - BUL_H;
      bul_act_mv_d = 1'b1;
    end

    rock_x_mv_d = x_rock_q;
    rock_y_mv_d = y_rock_q + RCK_STEP;
    if (rock_y_mv_d >= SCR_H) begin
      rock_x_mv_d = respawn_x_d;
      rock_y_mv_d = 19'd0;
    end

    bul_hit_d = bullet_active_q &&
                boxes_overlap(x_bullet_q, y_bullet_q, BUL_W, BUL_H, x_rock_q, y_rock_q, RCK_W, RCK_H);
    rock_x_ck_d = bul_hit_d ? respawn_x_d : x_rock_q;
    rock_y_ck_d = bul_hit_d ? 19'd0 : y_rock_q;
    // The ship is tested against the rock as it stands after any bullet hit respawned it.
    ship_hit_d = boxes_overlap(x_ship_q, y_ship_q, SHP_W, SHP_H, rock_x_ck_d, rock_y_ck_d, RCK_W, RCK_H);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_WAIT;
      x_ship_q        <= SHP_X0;
      y_ship_q        <= SHP_Y0;
      x_bullet_q      <= SCR_W;
      y_bullet_q      <= SCR_H;
      bullet_active_q <= 1'b0;
      x_rock_q        <= RCK_X0;
      y_rock_q        <= 19'd0;
      score_q         <= 8'd0;
      hit_q           <= 1'b0;
      game_over_q     <= 1'b0;
      fire_req_q      <= 1'b0;
      lfsr_q          <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      hit_q  <= 1'b0;
      if (fire_set) fire_req_q <= 1'b1;
      case (state_q)
        ST_WAIT: begin
          if (frame_tick && !game_over_q) state_q <= ST_MOVE;
        end
        ST_MOVE: begin
          x_ship_q        <= ship_x_mv_d;
          x_bullet_q      <= bul_x_mv_d;
          y_bullet_q      <= bul_y_mv_d;
          bullet_active_q <= bul_act_mv_d;
          x_rock_q        <= rock_x_mv_d;
          y_rock_q        <= rock_y_mv_d;
          fire_req_q      <= 1'b0;
          state_q         <= ST_CHECK;
        end
        ST_CHECK: begin
          x_rock_q <= rock_x_ck_d;
          y_rock_q <= rock_y_ck_d;
          if (bul_hit_d) begin
            x_bullet_q      <= SCR_W;
            y_bullet_q      <= SCR_H;
            bullet_active_q <= 1'b0;
            hit_q           <= 1'b1;
            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
          end
          if (ship_hit_d) game_over_q <= 1'b1;
          state_q <= ST_WAIT;
        end
        default: state_q <= ST_WAIT;
      endcase
    end
  end

  assign x_ship        = x_ship_q;
  assign y_ship        = y_ship_q;
  assign x_bullet      = x_bullet_q;
  assign y_bullet      = y_bullet_q;
  assign x_rock        = x_rock_q;
  assign y_rock        = y_rock_q;
  assign bullet_active = bullet_active_q;
  assign score         = score_q;
  assign hit           = hit_q;
  assign game_over     = game_over_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: frame-level reference model of the game rules, randomized play.
// Honours AUTOFIRE_EN the same way the design does.
module tb_sprite_motion_ctrl;

  localparam int SW = 640, SH = 480;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0;
  logic [18:0] x_ship, y_ship, x_bullet, y_bullet, x_rock, y_rock;
  logic        bullet_active, hit, game_over;
  logic [7:0]  score;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  sprite_motion_ctrl dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
    .x_ship(x_ship), .y_ship(y_ship), .x_bullet(x_bullet), .y_bullet(y_bullet),
    .x_rock(x_rock), .y_rock(y_rock), .bullet_active(bullet_active), .score(score),
    .hit(hit), .game_over(game_over), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // Free-running sequence generator matching the documented polynomial (x^16+x^14+x^13+x^11+1).
  logic [15:0] m_lfsr;
  always @(posedge clock) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  end

  // reference model state (frame granularity)
  int m_sx, m_sy, m_bx, m_by, m_rx, m_ry, m_score, m_shots;
  bit m_bact, m_go, m_hit, m_fire, m_fire_prev;

  logic [126:0] exp_q[$];
  logic [126:0] obs_vec, exp_vec;

  function automatic bit ov(int ax, int ay, int aw, int ah, int bx, int by, int bw, int bh);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  function automatic int respawn_x(logic [15:0] lf);
    int r;
    r = int'(lf[9:0]);
    return (r >= SW - 100) ? r - (SW - 100) : r;
  endfunction

  function automatic logic [126:0] model_vec();
    return {19'(m_sx), 19'(m_sy), 19'(m_bx), 19'(m_by), 19'(m_rx), 19'(m_ry),
            1'(m_bact), 8'(m_score), 1'(m_go), 1'b0, 1'(m_hit), 1'b0};
  endfunction

  task automatic model_reset();
    m_sx = 270; m_sy = 370; m_bx = SW; m_by = SH; m_bact = 0;
    m_rx = 270; m_ry = 0; m_score = 0; m_go = 0; m_hit = 0;
    m_fire = 0; m_fire_prev = 0; m_shots = 0;
  endtask

  task automatic model_frame(input logic [15:0] lf_mv, input logic [15:0] lf_ck);
    int nsx;
    m_hit = 0;
    if (m_go) return;
`ifdef AUTOFIRE_EN
    if (btn_fire) m_fire = 1;
`endif
    nsx = m_sx;
    if (btn_left && !btn_right)      nsx = (m_sx < 4) ? 0 : m_sx - 4;
    else if (btn_right && !btn_left) nsx = (m_sx + 4 > SW - 100) ? SW - 100 : m_sx + 4;
    if (m_bact) begin
      if (m_by < 8) begin m_bx = SW; m_by = SH; m_bact = 0; end
      else m_by = m_by - 8;
    end else if (m_fire) begin
      m_bx = m_sx + 40; m_by = m_sy - 20; m_bact = 1; m_shots++;
    end
    m_fire = 0;
    m_ry = m_ry + 2;
    if (m_ry >= SH) begin m_ry = 0; m_rx = respawn_x(lf_mv); end
    m_sx = nsx;
    if (m_bact && ov(m_bx, m_by, 20, 20, m_rx, m_ry, 100, 100)) begin
      m_bx = SW; m_by = SH; m_bact = 0;
      m_rx = respawn_x(lf_ck); m_ry = 0;
      if (m_score < 255) m_score++;
      m_hit = 1;
    end
    if (ov(m_sx, m_sy, 100, 100, m_rx, m_ry, 100, 100)) m_go = 1;
  endtask

  // driver tasks
  task automatic apply_reset();
    @(negedge clock);
    reset = 1; frame_tick = 0; btn_left = 0; btn_right = 0; btn_fire = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 0;
    model_reset();
  endtask

  task automatic set_buttons(input bit l, input bit r, input bit f);
    btn_left = l; btn_right = r; btn_fire = f;
    if (f && !m_fire_prev) m_fire = 1;
    m_fire_prev = f;
  endtask

  // One frame: tick held tick_len cycles; hit observed after MOVE, after CHECK, and one cycle later.
  task automatic do_frame(input int tick_len);
    logic [15:0] lf_mv, lf_ck;
    logic h0, h1, h2;
    @(negedge clock);
    frame_tick = 1;
    @(negedge clock);
    if (tick_len <= 1) frame_tick = 0;
    lf_mv = m_lfsr;
    @(negedge clock);
    if (tick_len == 2) frame_tick = 0;
    h0 = hit;
    lf_ck = m_lfsr;
    @(negedge clock);
    frame_tick = 0;
    h1 = hit;
    @(negedge clock);
    h2 = hit;
    obs_vec = {x_ship, y_ship, x_bullet, y_bullet, x_rock, y_rock,
               bullet_active, score, game_over, h0, h1, h2};
    model_frame(lf_mv, lf_ck);
    exp_q.push_back(model_vec());
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({x_ship, y_ship} !== {19'd270, 19'd370}) begin
      errors++; $display("FAIL reset_ship got (%0d,%0d) exp (270,370)", x_ship, y_ship);
    end
    checks++;
    if ({x_bullet, y_bullet, bullet_active} !== {19'd640, 19'd480, 1'b0}) begin
      errors++; $display("FAIL reset_bullet got (%0d,%0d,%0b) exp (640,480,0)", x_bullet, y_bullet, bullet_active);
    end
    checks++;
    if ({x_rock, y_rock} !== {19'd270, 19'd0}) begin
      errors++; $display("FAIL reset_rock got (%0d,%0d) exp (270,0)", x_rock, y_rock);
    end
    checks++;
    if ({score, hit, game_over, dbg_state} !== {8'd0, 1'b0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL reset_flags got score=%0d hit=%0b go=%0b st=%0d exp 0 0 0 0",
                         score, hit, game_over, dbg_state);
    end
  endtask

  task automatic test_idle();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      do_frame(1);
      exp_vec = exp_q.pop_front();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL idle_frame%0d got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if ({x_ship, y_ship, y_rock, x_bullet, y_bullet, score} !==
        {19'd270, 19'd370, 19'd20, 19'd640, 19'd480, 8'd0}) begin
      errors++; $display("FAIL idle_end got ship=(%0d,%0d) rock_y=%0d bullet=(%0d,%0d) score=%0d exp (270,370) 20 (640,480) 0",
                         x_ship, y_ship, y_rock, x_bullet, y_bullet, score);
    end
  endtask

  task automatic test_left_wall();
    apply_reset();
    set_buttons(1, 0, 0);
    for (int i = 0; i < 70; i++) begin
      do_frame(1);
      exp_vec = exp_q.pop_front();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL left_frame%0d got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (x_ship !== 19'd0) begin
      errors++; $display("FAIL left_wall got x=%0d exp 0", x_ship);
    end
    set_buttons(1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      do_frame(1);
      exp_vec = exp_q.pop_front();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL both_frame%0d got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (x_ship !== 19'd0) begin
      errors++; $display("FAIL both_hold got x=%0d exp 0", x_ship);
    end
  endtask

  // Ship at the left wall: the bullet misses the rock and flies until it parks.
  task automatic test_fire_flight();
    set_buttons(0, 0, 1);
    do_frame(1);
    set_buttons(0, 0, 0);
    exp_vec = exp_q.pop_front();
    checks++;
    if ({x_bullet, y_bullet, bullet_active} !== {19'd40, 19'd350, 1'b1}) begin
      errors++; $display("FAIL fire_spawn got (%0d,%0d,%0b) exp (40,350,1)", x_bullet, y_bullet, bullet_active);
    end
    for (int i = 0; i < 60 && m_bact; i++) begin
      do_frame(1);
      exp_vec = exp_q.pop_front();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL flight_frame%0d got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if ({x_bullet, y_bullet, bullet_active} !== {19'd640, 19'd480, 1'b0}) begin
      errors++; $display("FAIL flight_park got (%0d,%0d,%0b) exp (640,480,0)", x_bullet, y_bullet, bullet_active);
    end
  endtask

  task automatic test_hit();
    bit seen;
    apply_reset();
    set_buttons(0, 0, 1);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      do_frame(1);
      if (i == 0) set_buttons(0, 0, 0);
      exp_vec = exp_q.pop_front();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL hit_frame%0d got %h exp %h", i, obs_vec, exp_vec);
      end
      if (i == 0) begin
        checks++;
        if ({x_bullet, y_bullet} !== {19'd310, 19'd350}) begin
          errors++; $display("FAIL hit_spawn got (%0d,%0d) exp (310,350)", x_bullet, y_bullet);
        end
      end
      seen = m_hit;
    end
    checks++;
    if (!seen || score !== 8'd1 || y_rock !== 19'd0 || x_rock >= 19'd540 || bullet_active !== 1'b0) begin
      errors++; $display("FAIL hit_result got score=%0d rock=(%0d,%0d) active=%0b seen=%0b exp 1 (<540,0) 0 1",
                         score, x_rock, y_rock, bullet_active, seen);
    end
  endtask

  task automatic test_game_over();
    logic [126:0] frozen;
    apply_reset();
    for (int i = 0; i < 200 && !m_go; i++) begin
      do_frame(1);
      exp_vec = exp_q.pop_front();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL fall_frame%0d got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (game_over !== 1'b1) begin
      errors++; $display("FAIL game_over_set got %0b exp 1", game_over);
    end
    frozen = obs_vec;
    set_buttons(0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      do_frame(1);
      exp_vec = exp_q.pop_front();
      checks++;
      if (obs_vec !== exp_vec || obs_vec !== frozen) begin
        errors++; $display("FAIL frozen_frame%0d got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    apply_reset();
    checks++;
    if ({game_over, x_ship, y_rock, dbg_state} !== {1'b0, 19'd270, 19'd0, 2'd0}) begin
      errors++; $display("FAIL go_reset got go=%0b x=%0d rock_y=%0d st=%0d exp 0 270 0 0",
                         game_over, x_ship, y_rock, dbg_state);
    end
  endtask

  task automatic test_reset_mid_check();
    apply_reset();
    set_buttons(0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      do_frame(1);
      void'(exp_q.pop_front());
    end
    @(negedge clock);
    frame_tick = 1;
    @(negedge clock);
    frame_tick = 0;
    @(negedge clock);
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++; $display("FAIL mid_state got %0d exp 2", dbg_state);
    end
    reset = 1;
    @(negedge clock);
    reset = 0;
    btn_right = 0; btn_fire = 0;
    model_reset();
    obs_vec = {x_ship, y_ship, x_bullet, y_bullet, x_rock, y_rock,
               bullet_active, score, game_over, hit, 2'b00};
    exp_vec = model_vec();
    checks++;
    if (obs_vec !== exp_vec || dbg_state !== 2'd0) begin
      errors++; $display("FAIL mid_reset got %h st=%0d exp %h st=0", obs_vec, dbg_state, exp_vec);
    end
  endtask

  // A long tick must not start a second update while MOVE/CHECK are in progress.
  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_frame(2 + (i % 2));
      exp_vec = exp_q.pop_front();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL long_tick%0d got %h exp %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_hold_fire();
    int dut_shots, exp_shots;
    bit prev_act;
    apply_reset();
    set_buttons(1, 0, 0);
    for (int i = 0; i < 70; i++) begin
      do_frame(1);
      void'(exp_q.pop_front());
    end
    set_buttons(0, 0, 1);
    m_shots = 0;
    dut_shots = 0;
    prev_act = bullet_active;
    for (int i = 0; i < 150; i++) begin
      do_frame(1);
      exp_vec = exp_q.pop_front();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL hold_frame%0d got %h exp %h", i, obs_vec, exp_vec);
      end
      if (bullet_active && !prev_act) dut_shots++;
      prev_act = bullet_active;
    end
`ifdef AUTOFIRE_EN
    exp_shots = m_shots;
`else
    exp_shots = 1;
`endif
    checks++;
    if (dut_shots != exp_shots) begin
      errors++; $display("FAIL hold_shots got %0d exp %0d", dut_shots, exp_shots);
    end
  endtask

  task automatic test_random_play();
    for (int ep = 0; ep < 3; ep++) begin
      apply_reset();
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 3) == 0)
          set_buttons(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        do_frame(1 + ($urandom_range(0, 7) == 0 ? 1 : 0));
        exp_vec = exp_q.pop_front();
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++; $display("FAIL rand_ep%0d_frame%0d got %h exp %h", ep, i, obs_vec, exp_vec);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_left_wall();
    test_fire_flight();
    test_hit();
    test_game_over();
    test_reset_mid_check();
    test_back_to_back();
    test_hold_fire();
    test_random_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so a stuck run still reports.
  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
